// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder backed by a word-organised SRAM, with programmable wait states and byte-lane writes.
// Define AHB_SLV_ERR_EN to enable illegal-transfer checks and the two-cycle ERROR response.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = `ADDR_WIDTH,
    parameter int DATA_WIDTH  = `DATA_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic                  hready,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);
    // state  | meaning
    // S_IDLE | no data phase pending; OKAY, zero wait
    // S_DATA | data phase; hreadyout low until wait_cnt reaches WAIT_STATES
    // S_ERR1 | first ERROR cycle, hreadyout low
    // S_ERR2 | second ERROR cycle, hreadyout high; next transfer may be accepted
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_ERR1 = 2'b10,
        S_ERR2 = 2'b11
    } state_t;

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam int         LANE_BITS = $clog2(BYTES);
    localparam int         IDX_BITS  = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);
    localparam logic [3:0] WS        = 4'(WAIT_STATES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  illegal;
    logic                  commit;
    logic [IDX_BITS-1:0]   idx;
    logic [LANE_BITS-1:0]  lane_off;
    logic [2:0]            size_eff;
    logic [BYTES-1:0]      lane_en;
    logic                  unused_bits;

    assign accept   = hsel & hready & htrans[1];
    assign idx      = haddr_q[IDX_BITS+LANE_BITS-1:LANE_BITS];
    assign lane_off = haddr_q[LANE_BITS-1:0];
    assign size_eff = (hsize_q > MAX_SIZE) ? MAX_SIZE : hsize_q;
    assign commit   = hresetn & (state == S_DATA) & hreadyout & hwrite_q;
    assign hrdata   = (state == S_DATA && !hwrite_q) ? mem[idx] : '0;
    assign unused_bits = ^{hburst, htrans[0], haddr_q};

`ifdef AHB_SLV_ERR_EN
    localparam longint MEM_BYTES = longint'(MEM_DEPTH) * BYTES;
    logic [LANE_BITS-1:0] align_mask;

    assign align_mask = ~({LANE_BITS{1'b1}} << hsize);
    assign illegal    = (64'(haddr) >= 64'(MEM_BYTES)) | (hsize > MAX_SIZE)
                      | (|(haddr[LANE_BITS-1:0] & align_mask));
    assign hresp      = state[1];
`else
    assign illegal    = 1'b0;
    assign hresp      = 1'b0;
`endif

    // Comparing lane and offset above the access size both selects the lanes and aligns down.
    always_comb begin
        lane_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            lane_en[b] = (LANE_BITS'(b) >> size_eff) == (lane_off >> size_eff);
        end
    end

    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            hreadyout <= 1'b1;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
        end else if (hreadyout) begin
            wait_cnt <= '0;
            if (accept) begin
                haddr_q  <= haddr;
                hwrite_q <= hwrite;
                hsize_q  <= hsize;
                if (illegal) begin
                    state     <= S_ERR1;
                    hreadyout <= 1'b0;
                end else begin
                    state     <= S_DATA;
                    hreadyout <= (WS == 4'd0);
                end
            end else begin
                state     <= S_IDLE;
                hreadyout <= 1'b1;
            end
        end else begin
            case (state)
                S_DATA: begin
                    wait_cnt  <= wait_cnt + 4'd1;
                    hreadyout <= (wait_cnt + 4'd1 == WS);
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/ahb_lite_sram_slave.md
# ahb_lite_sram_slave

AHB-Lite responder that terminates the bus driven by the testbench master and backs it with a word-organised on-chip SRAM model. It samples address-phase controls, completes data phases with a programmable number of wait states, applies byte-lane write strobes, and returns read data and OKAY/ERROR responses. It is the DUT-side counterpart used to close the loop on the AHB-Lite verification environment.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH, byte address width
- DATA_WIDTH, `DATA_WIDTH, data bus width; one of 32 or 64
- MEM_DEPTH, 256, number of DATA_WIDTH words in the SRAM
- WAIT_STATES, 0, wait cycles inserted in every NONSEQ/SEQ data phase (0–15)

- hclk  input  1  bus clock; all state updates on rising edge
- hresetn  input  1  synchronous, active-low reset
- hsel  input  1  slave select (address phase)
- hready  input  1  bus-wide ready; address phase accepted only when high
- haddr  input  ADDR_WIDTH  byte address
- htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hwrite  input  1  1 = write, 0 = read
- hsize  input  3  transfer size, bytes = 2**hsize
- hburst  input  3  burst type; sampled but not used for decoding
- hwdata  input  DATA_WIDTH  write data (data phase)
- hrdata  output  DATA_WIDTH  read data (data phase)
- hreadyout  output  1  slave ready
- hresp  output  1  0 = OKAY, 1 = ERROR

## Operation
- Accept: hsel & hready & htrans[1] on a rising edge registers haddr, hwrite, hsize; the data phase starts the next cycle.
- IDLE/BUSY, or hsel low: no data phase; the slave responds OKAY with zero wait.
- FSM states: S_IDLE, S_DATA, S_ERR1, S_ERR2.
  - S_IDLE → S_DATA on an accepted legal transfer.
  - S_IDLE → S_ERR1 on an accepted illegal transfer.
  - S_DATA holds while wait_cnt < WAIT_STATES, with hreadyout=0.
  - The final S_DATA cycle has hreadyout=1. On that cycle the next state is chosen from the address phase sampled in it (pipelined back-to-back transfers).
  - S_ERR1: hresp=1, hreadyout=0. Always → S_ERR2.
  - S_ERR2: hresp=1, hreadyout=1. Next state is chosen like the final S_DATA cycle.
- Word index = haddr_q[log2(MEM_DEPTH*DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)]. Lane offset = low haddr_q bits. Little-endian.
- Write: on the final S_DATA edge, only the 2**hsize bytes at the lane offset are updated from the matching hwdata lanes.
- Read: during S_DATA, hrdata = full word mem[index], all lanes. Outside read data phases, hrdata = 0.
- Illegal transfer (checked only when AHB_SLV_ERR_EN is defined), any of:
  - haddr ≥ MEM_DEPTH*DATA_WIDTH/8;
  - haddr not aligned to 2**hsize;
  - 2**hsize > DATA_WIDTH/8.
- An illegal transfer never modifies memory.

## Timing
- Reset values, applied on the first edge with hresetn=0:
  - state S_IDLE, wait_cnt 0, hreadyout 1, hresp 0, hrdata 0.
  - SRAM contents are not reset.
- Reset during S_DATA: the pending write is dropped and the bus returns to idle on the next cycle.
- Latency: a read or write completes 1+WAIT_STATES cycles after address acceptance.
- Write followed immediately by a read of the same word: the read data phase returns the newly written value. The write commits on the edge that starts the read data phase.
- An error response is always exactly two cycles, independent of WAIT_STATES.
- A new transfer presented during S_ERR2 is accepted normally.
- BUSY inside a burst: OKAY, zero wait, no memory access.

## Configuration
- AHB_SLV_ERR_EN defined: illegal-transfer checks active; the two-cycle ERROR response is generated.
- AHB_SLV_ERR_EN undefined:
  - hresp is tied to 0 and S_ERR1/S_ERR2 are unreachable.
  - Out-of-range addresses wrap modulo the memory size.
  - Misaligned addresses are aligned down to 2**hsize.
  - Oversized hsize is treated as a full-word access.

## Test plan
- Reset: hresetn=0 for 2 cycles → hreadyout=1, hresp=0, hrdata=0.
- WAIT_STATES=0, DATA_WIDTH=32:
  - NONSEQ write 0xDEADBEEF to 0x10, hsize=2;
  - then NONSEQ read of 0x10 back-to-back;
  - → hrdata=0xDEADBEEF in the read data phase, no wait cycles.
- Byte strobes:
  - word write 0x00000000 to 0x20;
  - byte write 0xAB at 0x22 (hsize=0, hwdata=0x00AB0000);
  - → a read of 0x20 returns 0x00AB0000.
- WAIT_STATES=3: a read at 0x04 → hreadyout low for exactly 3 cycles, then high with valid hrdata on the 4th data-phase cycle.
- With AHB_SLV_ERR_EN: a write to 0x401 with hsize=2 and MEM_DEPTH=256 →
  - cycle 1: hresp=1, hreadyout=0;
  - cycle 2: hresp=1, hreadyout=1;
  - memory unchanged.
- Without AHB_SLV_ERR_EN: a write of 0x12345678 to 0x400 (MEM_DEPTH=256) → a read of 0x000 returns 0x12345678 with hresp=0.
